// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//   MEM-stage controller sitting between the EX/MEM and MEM/WB pipeline
//   registers. Loads and stores are issued to a variable-latency data memory
//   over a req/ack handshake. While an access is outstanding, stall freezes
//   the upstream stages. Results bound for writeback are registered here.
//
//   Optional feature macro: STORE_BUFFER_EN
//     Adds a one-entry posted-write buffer. A store retires immediately and
//     drains in the background from the DRAIN state. When the macro is
//     undefined, stores block exactly like loads.
//
// Ports
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   ex_valid       EX/MEM slot holds a real instruction
//   MemRead        load request
//   MemWrite       store request (wins over MemRead)
//   RegWrite_in    writeback control from EX/MEM
//   MemtoReg_in    writeback control from EX/MEM
//   Rd_in          destination register from EX/MEM
//   alu_result     ALU result / effective address
//   store_data     store data
//   stall          combinational freeze for PC, IF/ID, ID/EX, EX/MEM
//   dm_req         registered memory request
//   dm_we          1 = write access
//   dm_addr        registered memory address
//   dm_wdata       registered memory write data
//   dm_ack         memory done; dm_rdata valid in the same cycle
//   dm_rdata       memory read data
//   wb_valid       MEM/WB slot valid
//   wb_RegWrite    writeback enable, forced to 0 when the slot is empty
//   wb_MemtoReg    writeback mux select
//   wb_Rd          writeback destination
//   wb_alu_result  ALU result passed to writeback
//   wb_mem_data    load data passed to writeback
//   bus_err        sticky timeout flag, cleared only by rst
// ---------------------------------------------------------------------------
module mem_access_stage #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              RegWrite_in,
  input  logic              MemtoReg_in,
  input  logic [3:0]        Rd_in,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  output logic              stall,
  output logic              dm_req,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              wb_valid,
  output logic              wb_RegWrite,
  output logic              wb_MemtoReg,
  output logic [3:0]        wb_Rd,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [DATA_W-1:0] wb_mem_data,
  output logic              bus_err
);

`ifdef STORE_BUFFER_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DRAIN = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1} state_t;
`endif

  // The last WAIT/DRAIN cycle allowed before the access is abandoned.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_next;
  logic [7:0] wait_cnt;
  logic       mem_op;
  logic       timeout_hit;

  assign mem_op      = ex_valid & (MemRead | MemWrite);
  // An ack in the final cycle wins over the timeout.
  assign timeout_hit = (wait_cnt == TIMEOUT_LAST) & ~dm_ack;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (mem_op) begin
`ifdef STORE_BUFFER_EN
          state_next = MemWrite ? S_DRAIN : S_WAIT;
`else
          state_next = S_WAIT;
`endif
        end
      end
      S_WAIT: begin
        if (dm_ack || timeout_hit) state_next = S_IDLE;
      end
`ifdef STORE_BUFFER_EN
      S_DRAIN: begin
        if (dm_ack || timeout_hit) state_next = S_IDLE;
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // Stall output. It is forced low during reset so the upstream stages are
  // released at the same moment the outstanding request is dropped.
  always_comb begin
    stall = 1'b0;
    case (state)
      S_IDLE: begin
`ifdef STORE_BUFFER_EN
        stall = mem_op & ~MemWrite;
`else
        stall = mem_op;
`endif
      end
      S_WAIT:  stall = ~dm_ack & ~timeout_hit;
`ifdef STORE_BUFFER_EN
      S_DRAIN: stall = mem_op;
`endif
      default: stall = 1'b0;
    endcase
    if (rst) stall = 1'b0;
  end

  // Memory interface, timeout counter and the MEM/WB register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dm_req        <= 1'b0;
      dm_we         <= 1'b0;
      dm_addr       <= '0;
      dm_wdata      <= '0;
      wait_cnt      <= '0;
      wb_valid      <= 1'b0;
      wb_RegWrite   <= 1'b0;
      wb_MemtoReg   <= 1'b0;
      wb_Rd         <= '0;
      wb_alu_result <= '0;
      wb_mem_data   <= '0;
      bus_err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_op) begin
            dm_req   <= 1'b1;
            dm_we    <= MemWrite;
            dm_addr  <= alu_result;
            dm_wdata <= store_data;
            wait_cnt <= '0;
`ifdef STORE_BUFFER_EN
            // A posted store retires now while the buffer drains.
            if (MemWrite) begin
              wb_valid      <= 1'b1;
              wb_RegWrite   <= RegWrite_in;
              wb_MemtoReg   <= MemtoReg_in;
              wb_Rd         <= Rd_in;
              wb_alu_result <= alu_result;
            end else begin
              wb_valid    <= 1'b0;
              wb_RegWrite <= 1'b0;
            end
`else
            wb_valid    <= 1'b0;
            wb_RegWrite <= 1'b0;
`endif
          end else begin
            wb_valid      <= ex_valid;
            wb_RegWrite   <= ex_valid & RegWrite_in;
            wb_MemtoReg   <= MemtoReg_in;
            wb_Rd         <= Rd_in;
            wb_alu_result <= alu_result;
          end
        end

        S_WAIT: begin
          // The stalled instruction is still held in EX/MEM, so its
          // writeback controls are taken straight from the inputs.
          if (dm_ack) begin
            dm_req        <= 1'b0;
            wb_valid      <= 1'b1;
            wb_RegWrite   <= RegWrite_in;
            wb_MemtoReg   <= MemtoReg_in;
            wb_Rd         <= Rd_in;
            wb_alu_result <= alu_result;
            if (!dm_we) wb_mem_data <= dm_rdata;
          end else if (timeout_hit) begin
            // Retire the instruction without a register write.
            dm_req        <= 1'b0;
            bus_err       <= 1'b1;
            wb_valid      <= 1'b1;
            wb_RegWrite   <= 1'b0;
            wb_MemtoReg   <= MemtoReg_in;
            wb_Rd         <= Rd_in;
            wb_alu_result <= alu_result;
          end else begin
            wait_cnt    <= wait_cnt + 8'd1;
            wb_valid    <= 1'b0;
            wb_RegWrite <= 1'b0;
          end
        end

`ifdef STORE_BUFFER_EN
        S_DRAIN: begin
          if (dm_ack) begin
            dm_req <= 1'b0;
          end else if (timeout_hit) begin
            dm_req  <= 1'b0;
            bus_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
          // Non-memory instructions keep flowing while the buffer drains.
          if (mem_op) begin
            wb_valid    <= 1'b0;
            wb_RegWrite <= 1'b0;
          end else begin
            wb_valid      <= ex_valid;
            wb_RegWrite   <= ex_valid & RegWrite_in;
            wb_MemtoReg   <= MemtoReg_in;
            wb_Rd         <= Rd_in;
            wb_alu_result <= alu_result;
          end
        end
`endif

        default: begin
          dm_req      <= 1'b0;
          wb_valid    <= 1'b0;
          wb_RegWrite <= 1'b0;
        end
      endcase
    end
  end

endmodule
